seq_restoring_divider: RTL

- Multi-cycle unsigned restoring divider; the subtractive counterpart to the accumulator datapath's ripple-carry adder.
- Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Uses an internal (WIDTH+1)-bit subtractor, computed as R + ~D + 1.
- Sits beside the accumulator as its divide unit, controlled by a start/busy/done handshake.

---
 rtl/seq_restoring_divider.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, results held until the next operation completes.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RW-1:0]    r_rem;
  logic [RW-1:0]    w_rem_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] w_d_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_dbz;
  logic             w_dbz_nxt;

  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_remo_nxt;
  logic             w_dbzo_nxt;

  logic [RW-1:0]    w_rs;
  logic [RW-1:0]    w_trial;

  // Shift {R,Q} left by one; trial subtraction as R + ~D + 1 in WIDTH+1 bits.
  assign w_rs    = RW'({r_rem, r_q[WIDTH-1]});
  assign w_trial = w_rs + ~{1'b0, r_d} + RW'(1);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_q         <= w_q_nxt;
      r_d         <= w_d_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dbz       <= w_dbz_nxt;
      busy        <= w_busy_nxt;
      done        <= w_done_nxt;
      quotient    <= w_quo_nxt;
      remainder   <= w_remo_nxt;
      div_by_zero <= w_dbzo_nxt;
    end
  end

  // Next-state, datapath and output-register logic
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_q_nxt     = r_q;
    w_d_nxt     = r_d;
    w_cnt_nxt   = r_cnt;
    w_dbz_nxt   = r_dbz;
    w_done_nxt  = 1'b0;
    w_quo_nxt   = quotient;
    w_remo_nxt  = remainder;
    w_dbzo_nxt  = div_by_zero;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            w_d_nxt     = divisor;
            w_q_nxt     = dividend;
            w_rem_nxt   = '0;
            w_cnt_nxt   = CW'(WIDTH);
            w_dbz_nxt   = 1'b0;
            w_state_nxt = S_CALC;
          end else begin
            // Divide by zero skips the iteration and reports all-ones quotient.
            w_q_nxt     = '1;
            w_rem_nxt   = {1'b0, dividend};
            w_dbz_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_CALC: begin
        if (!w_trial[RW-1]) begin
          w_rem_nxt = w_trial;
          w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
        end else begin
          w_rem_nxt = w_rs;
          w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
        end
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_quo_nxt   = r_q;
        w_remo_nxt  = r_rem[WIDTH-1:0];
        w_dbzo_nxt  = r_dbz;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_CALC);
  end

endmodule
